// File: rtl/osd_uart_arbiter_if.sv
// Character-channel bundle between the producers, the line-locked arbiter and the DEM-UART.
// Handshake: a beat moves on a rising clk edge when valid and ready are both high; valid, once raised, is held with stable data until that beat.
interface osd_uart_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ*8-1:0] in_char;
    logic [NREQ-1:0]   in_valid;
    logic [NREQ-1:0]   in_ready;
    logic [7:0]        out_char;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_char, in_valid, out_ready,
        input  in_ready, out_char, out_valid
    );

    modport slave (
        input  in_char, in_valid, out_ready,
        output in_ready, out_char, out_valid
    );
endinterface

// File: rtl/osd_uart_arbiter.sv
// Line-locked round-robin arbiter feeding one DEM-UART character channel through a one-entry output slot.
// Optional macro OSD_UART_ARB_PREFIX_EN prefixes every granted line with "<id>:".
module osd_uart_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    osd_uart_arbiter_if.slave       bus,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic [1:0]              state_dbg
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TAG    = 2'd1,
        SEP    = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   idle_cnt;
    logic [7:0]      out_char_q;
    logic            out_valid_q;
    logic [NREQ-1:0] in_ready;
    logic            load_ok;
    logic            xfer;
    logic            hit;
    logic            timeout_hit;
    logic [GW-1:0]   next_gnt;
    logic [7:0]      gnt_char;
    int              idx;

    assign load_ok     = !out_valid_q || bus.out_ready;
    assign gnt_char    = bus.in_char[int'(grant_id)*8 +: 8];
    assign xfer        = |(bus.in_valid & in_ready);
    assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == CW'(TIMEOUT - 1));

    // Only the lock holder may see ready, and only when the slot can take a char.
    always_comb begin
        in_ready = '0;
        if (state == LOCKED && load_ok) in_ready[grant_id] = 1'b1;
    end

    // Rotating search that starts just after the last grant.
    always_comb begin
        hit      = 1'b0;
        next_gnt = grant_id;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(grant_id) + k) % NREQ;
            if (!hit && bus.in_valid[idx]) begin
                hit      = 1'b1;
                next_gnt = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_id    <= GW'(NREQ - 1);
            out_char_q  <= 8'h00;
            out_valid_q <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            if (bus.out_ready) out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        grant_id <= next_gnt;
                        idle_cnt <= '0;
`ifdef OSD_UART_ARB_PREFIX_EN
                        state    <= TAG;
`else
                        state    <= LOCKED;
`endif
                    end
                end
`ifdef OSD_UART_ARB_PREFIX_EN
                TAG: begin
                    if (load_ok) begin
                        out_char_q  <= 8'h30 + 8'(grant_id);
                        out_valid_q <= 1'b1;
                        state       <= SEP;
                    end
                end
                SEP: begin
                    if (load_ok) begin
                        out_char_q  <= 8'h3a;
                        out_valid_q <= 1'b1;
                        idle_cnt    <= '0;
                        state       <= LOCKED;
                    end
                end
`endif
                LOCKED: begin
                    if (xfer) begin
                        out_char_q  <= gnt_char;
                        out_valid_q <= 1'b1;
                        idle_cnt    <= '0;
                        if (gnt_char == 8'h0a) state <= IDLE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_char  = out_char_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;
endmodule

// File: doc/osd_uart_arbiter.md
# osd_uart_arbiter

Line-locked round-robin arbiter that shares one `osd_dem_uart` output character channel (`out_char`/`out_valid`/`out_ready`) between several on-chip character sources. A grant is held for a whole text line, so output from different requesters never interleaves inside a line. The grant is released on newline or on an idle timeout. The block sits between the software/testbench character producers and the DEM-UART, and carries one registered output stage.

## Interface
- `NREQ`, default 4: number of requesters, 2..10.
- `TIMEOUT`, default 256: idle cycles of the granted requester before forced release. 0 disables the timeout.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_char`  in  NREQ*8  character of requester i in bits [8i+7:8i].
- `in_valid`  in  NREQ  per-requester valid.
- `in_ready`  out  NREQ  per-requester ready; at most one bit is high.
- `out_char`  out  8  character to DEM-UART.
- `out_valid`  out  1  output valid.
- `out_ready`  in  1  DEM-UART ready.
- `grant_id`  out  $clog2(NREQ)  index of the current or last granted requester.
- `busy`  out  1  high when a requester holds the lock, i.e. state is not IDLE.

## Operation
- Output register: a one-entry slot (`out_char`, `out_valid`). The slot loads when it is empty or `out_ready` is high.
- `load_ok = !out_valid | out_ready`.
- States:
  - IDLE
  - TAG (prefix builds only)
  - SEP (prefix builds only)
  - LOCKED
- IDLE:
  - Search `in_valid` starting at `(grant_id+1) mod NREQ`, wrapping, and pick the first set bit.
  - On a hit: register `grant_id`, then go to LOCKED (or TAG in prefix builds).
  - No char is transferred in the IDLE cycle.
- LOCKED:
  - `in_ready[grant_id] = load_ok`; all other `in_ready` bits are 0.
  - A transfer occurs when `in_valid[grant_id] & in_ready[grant_id]`. The char is copied to the slot.
  - A transferred char equal to 8'h0a causes IDLE on the next cycle.
- Timeout counter, width $clog2(TIMEOUT+1):
  - Cleared on entering LOCKED and on every transfer.
  - Otherwise increments each LOCKED cycle.
  - When it reaches TIMEOUT-1 without a transfer, the next state is IDLE.
  - Saturating; never wraps.
- A requester dropping `in_valid` mid-line keeps the lock until newline or timeout.
- Round-robin pointer equals `grant_id`. It updates only on a new grant.
- Simultaneous newline and other waiting requesters: one IDLE cycle follows, then the next requester in rotation is granted.
- Reset (async):
  - state=IDLE, `out_valid`=0, `out_char`=8'h00.
  - `grant_id`=NREQ-1, so requester 0 wins the first arbitration.
  - `in_ready`=0, `busy`=0, counter=0.
  - Reset mid-line discards the slot content and the lock.

## Timing
- `in_ready` depends combinationally on `out_ready`, `out_valid` and the registered state/`grant_id`. It never depends on `in_valid`.
- Latency: a char accepted in cycle t appears on `out_char` with `out_valid`=1 in cycle t+1.
- Throughput: 1 char/cycle while `out_ready`=1 and LOCKED.
- Per-line overhead:
  - 1 cycle (IDLE) in plain builds.
  - 3 cycles (IDLE, TAG, SEP) in prefix builds.
- While `out_valid`=1 and `out_ready`=0, `out_char` is held stable.
- A valid output is never withdrawn.
- Grant-to-first-transfer: `in_ready[i]` can rise at earliest one cycle after `in_valid[i]` is sampled in IDLE.

## Configuration
- Macro: `OSD_UART_ARB_PREFIX_EN`.
- Defined:
  - After each grant, TAG loads ASCII `8'h30+grant_id` into the slot.
  - SEP then loads `8'h3a` (':').
  - Each state waits on `load_ok` before advancing.
  - The timeout counter is inactive in TAG/SEP.
  - `in_ready` is 0 in TAG/SEP.
- Undefined:
  - TAG/SEP are not synthesized.
  - IDLE goes directly to LOCKED.
  - The output stream is the raw concatenation of lines.

## Test plan
- Single line: requester 0 drives "Hi\n" (8'h48, 8'h69, 8'h0a), `out_ready`=1 → `out_char` sequence 48,69,0a on consecutive cycles starting 2 cycles after `in_valid`; `busy` falls the cycle after 0a is accepted; `grant_id`=0.
- Fairness: requesters 1 and 2 each present "A\n"/"B\n" from reset → output 41,0a,42,0a; grant order 1 then 2; no interleaving.
- Backpressure: `out_ready`=0 for 5 cycles mid-line → `out_char`/`out_valid` stable; `in_ready[grant]`=0; no char lost or duplicated after release.
- Timeout: TIMEOUT=8; requester 0 sends 8'h41 then deasserts valid, requester 3 waiting → `busy` drops after 8 idle LOCKED cycles; requester 3 granted next.
- Reset mid-line: `rst_n` asserted while slot holds 8'h65 → `out_valid`=0 immediately (async); after release, requester 0 wins first.
- Prefix build (`OSD_UART_ARB_PREFIX_EN`): requester 1 sends "x\n" → output 31,3a,78,0a.
